// File: rtl/hmmm_control.sv
// Microcoded step sequencer for the Hmmm CPU: fetch T0/T1, execute T2..T4.
// Strobes are decoded combinationally from the current step and ir_data.
module hmmm_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_data,
  input  logic [15:0] bus,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        pc_out,
  output logic        pc_jump,
  output logic        pc_increment,
  output logic        tmp0_in,
  output logic        tmp1_in,
  output logic        tmp0_out,
  output logic        tmp1_out,
  output logic        alu_out,
  output logic [2:0]  alu_op,
  output logic [3:0]  reg_sel,
  output logic        reg_in,
  output logic        reg_out,
  output logic        ir_in,
  output logic        ir_out,
  output logic        in_out,
  output logic        out_in,
  output logic        halt
);

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, HALT
  } state_t;

  state_t state, state_nx;
  logic   take, cond;

  logic [3:0] op, x, y, z;
  logic       is_halt, is_len3, is_len5, is_mem_r;

  assign op = ir_data[15:12];
  assign x  = ir_data[11:8];
  assign y  = ir_data[7:4];
  assign z  = ir_data[3:0];

  assign is_halt  = (ir_data == 16'h0000);
  assign is_mem_r = (z == 4'd0) || (z == 4'd1);
  assign is_len3  = (op == 4'd0) || (op == 4'd1) ||
                    ((op == 4'd4) && !is_mem_r);
  assign is_len5  = (op >= 4'd5) && (op <= 4'd10);

  // Branch sense from the low opcode bits of 11xx
  always_comb begin
    cond = 1'b0;
    unique case (op[1:0])
      2'b00: cond = (bus == 16'h0000);
      2'b01: cond = (bus != 16'h0000);
      2'b10: cond = !bus[15] && (bus != 16'h0000);
      2'b11: cond = bus[15];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T0;
      take  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == T2)
        take <= cond;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      T0: state_nx = T1;
      T1: state_nx = T2;
      T2: begin
        if (is_halt)      state_nx = HALT;
        else if (is_len3) state_nx = T0;
        else              state_nx = T3;
      end
      T3:   state_nx = is_len5 ? T4 : T0;
      T4:   state_nx = T0;
      HALT: state_nx = HALT;
      default: state_nx = T0;
    endcase
  end

  always_comb begin
    mar_in       = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    pc_out       = 1'b0;
    pc_jump      = 1'b0;
    pc_increment = 1'b0;
    tmp0_in      = 1'b0;
    tmp1_in      = 1'b0;
    tmp0_out     = 1'b0;
    tmp1_out     = 1'b0;
    alu_out      = 1'b0;
    alu_op       = 3'd0;
    reg_sel      = 4'd0;
    reg_in       = 1'b0;
    reg_out      = 1'b0;
    ir_in        = 1'b0;
    ir_out       = 1'b0;
    in_out       = 1'b0;
    out_in       = 1'b0;
    halt         = 1'b0;
    if (!rst) begin
      unique case (state)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          mdr_out      = 1'b1;
          ir_in        = 1'b1;
          pc_increment = 1'b1;
        end
        T2: begin
          unique case (op)
            4'd0: begin
              unique case (ir_data[7:0])
                8'h01: begin
                  in_out  = 1'b1;
                  reg_in  = 1'b1;
                  reg_sel = x;
                end
                8'h02: begin
                  reg_out = 1'b1;
                  out_in  = 1'b1;
                  reg_sel = x;
                end
                8'h03: begin
                  reg_out = 1'b1;
                  pc_jump = 1'b1;
                  reg_sel = x;
                end
                default: ;
              endcase
            end
            4'd1: begin
              ir_out  = 1'b1;
              reg_in  = 1'b1;
              reg_sel = x;
            end
            4'd2, 4'd3: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            4'd4: begin
              if (is_mem_r) begin
                reg_out = 1'b1;
                mar_in  = 1'b1;
                reg_sel = y;
              end
            end
            4'd5: begin
              reg_out = 1'b1;
              tmp0_in = 1'b1;
              reg_sel = x;
            end
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
              reg_out = 1'b1;
              tmp0_in = 1'b1;
              reg_sel = y;
            end
            4'd11: begin
              pc_out  = 1'b1;
              reg_in  = 1'b1;
              reg_sel = x;
            end
            default: begin
              reg_out = 1'b1;
              reg_sel = x;
            end
          endcase
        end
        T3: begin
          unique case (op)
            4'd2: begin
              mdr_out = 1'b1;
              reg_in  = 1'b1;
              reg_sel = x;
            end
            4'd3: begin
              reg_out = 1'b1;
              mdr_in  = 1'b1;
              reg_sel = x;
            end
            4'd4: begin
              if (z == 4'd0) begin
                mdr_out = 1'b1;
                reg_in  = 1'b1;
                reg_sel = x;
              end else if (z == 4'd1) begin
                reg_out = 1'b1;
                mdr_in  = 1'b1;
                reg_sel = x;
              end
            end
            4'd5: begin
              ir_out  = 1'b1;
              tmp1_in = 1'b1;
            end
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
              reg_out = 1'b1;
              tmp1_in = 1'b1;
              reg_sel = z;
            end
            4'd11: begin
              ir_out  = 1'b1;
              pc_jump = 1'b1;
            end
            4'd12, 4'd13, 4'd14, 4'd15: begin
              ir_out  = take;
              pc_jump = take;
            end
            default: ;
          endcase
        end
        T4: begin
          if (is_len5) begin
            alu_out = 1'b1;
            reg_in  = 1'b1;
            reg_sel = x;
            // addn shares the add slot; ALU ops start at opcode 6
            if (op != 4'd5)
              alu_op = 3'(op - 4'd6);
          end
        end
        HALT: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmmm_control.sv
// Bench for hmmm_control: step-table model compared every cycle,
// plus literal spot checks from hand-worked instruction traces.
module tb_hmmm_control;

  typedef struct packed {
    logic       mar_in, mdr_in, mdr_out, pc_out, pc_jump, pc_increment;
    logic       tmp0_in, tmp1_in, tmp0_out, tmp1_out, alu_out;
    logic [2:0] alu_op;
    logic [3:0] reg_sel;
    logic       reg_in, reg_out, ir_in, ir_out, in_out, out_in, halt;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir_data, bus;
  ov_t         d;

  int n_total = 0;
  int n_pass  = 0;

  hmmm_control dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .bus(bus),
    .mar_in(d.mar_in), .mdr_in(d.mdr_in), .mdr_out(d.mdr_out),
    .pc_out(d.pc_out), .pc_jump(d.pc_jump),
    .pc_increment(d.pc_increment),
    .tmp0_in(d.tmp0_in), .tmp1_in(d.tmp1_in),
    .tmp0_out(d.tmp0_out), .tmp1_out(d.tmp1_out),
    .alu_out(d.alu_out), .alu_op(d.alu_op), .reg_sel(d.reg_sel),
    .reg_in(d.reg_in), .reg_out(d.reg_out), .ir_in(d.ir_in),
    .ir_out(d.ir_out), .in_out(d.in_out), .out_in(d.out_in),
    .halt(d.halt)
  );

  always #5 clk = ~clk;

  // Instruction length in cycles, straight from the latency table
  function automatic int ilen(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    if (op <= 4'd1) return 3;
    if (op == 4'd4) return (ir[3:0] <= 4'd1) ? 4 : 3;
    if (op >= 4'd5 && op <= 4'd10) return 5;
    return 4;
  endfunction

  function automatic ov_t model_out(input logic r, input int st,
                                    input logic h, input logic tk,
                                    input logic [15:0] ir);
    ov_t o;
    logic [3:0] op, x, y, z;
    o  = '0;
    op = ir[15:12];
    x  = ir[11:8];
    y  = ir[7:4];
    z  = ir[3:0];
    if (r) return o;
    if (h) begin
      o.halt = 1'b1;
      return o;
    end
    if (st == 0) begin
      o.pc_out = 1; o.mar_in = 1;
    end else if (st == 1) begin
      o.mdr_out = 1; o.ir_in = 1; o.pc_increment = 1;
    end else if (st == 2) begin
      if (op == 0 && ir[7:0] == 8'h01) begin
        o.in_out = 1; o.reg_in = 1; o.reg_sel = x;
      end else if (op == 0 && ir[7:0] == 8'h02) begin
        o.reg_out = 1; o.out_in = 1; o.reg_sel = x;
      end else if (op == 0 && ir[7:0] == 8'h03) begin
        o.reg_out = 1; o.pc_jump = 1; o.reg_sel = x;
      end else if (op == 1) begin
        o.ir_out = 1; o.reg_in = 1; o.reg_sel = x;
      end else if (op == 2 || op == 3) begin
        o.ir_out = 1; o.mar_in = 1;
      end else if (op == 4 && z <= 1) begin
        o.reg_out = 1; o.mar_in = 1; o.reg_sel = y;
      end else if (op == 5) begin
        o.reg_out = 1; o.tmp0_in = 1; o.reg_sel = x;
      end else if (op >= 6 && op <= 10) begin
        o.reg_out = 1; o.tmp0_in = 1; o.reg_sel = y;
      end else if (op == 11) begin
        o.pc_out = 1; o.reg_in = 1; o.reg_sel = x;
      end else if (op >= 12) begin
        o.reg_out = 1; o.reg_sel = x;
      end
    end else if (st == 3) begin
      if (op == 2 || (op == 4 && z == 0)) begin
        o.mdr_out = 1; o.reg_in = 1; o.reg_sel = x;
      end else if (op == 3 || (op == 4 && z == 1)) begin
        o.reg_out = 1; o.mdr_in = 1; o.reg_sel = x;
      end else if (op == 5) begin
        o.ir_out = 1; o.tmp1_in = 1;
      end else if (op >= 6 && op <= 10) begin
        o.reg_out = 1; o.tmp1_in = 1; o.reg_sel = z;
      end else if (op == 11 || (op >= 12 && tk)) begin
        o.ir_out = 1; o.pc_jump = 1;
      end
    end else if (st == 4) begin
      o.alu_out = 1; o.reg_in = 1; o.reg_sel = x;
      case (op)
        4'd7:    o.alu_op = 3'd1;
        4'd8:    o.alu_op = 3'd2;
        4'd9:    o.alu_op = 3'd3;
        4'd10:   o.alu_op = 3'd4;
        default: o.alu_op = 3'd0;
      endcase
    end
    return o;
  endfunction

  int   m_step = 0;
  logic m_halt = 1'b0;
  logic m_take = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_step = 0; m_halt = 0; m_take = 0;
    end else if (!m_halt) begin
      if (m_step == 2) begin
        case (ir_data[13:12])
          2'b00: m_take = (bus == 0);
          2'b01: m_take = (bus != 0);
          2'b10: m_take = ($signed(bus) > 0);
          default: m_take = ($signed(bus) < 0);
        endcase
      end
      if (m_step == 2 && ir_data == 16'h0000) m_halt = 1;
      else if (m_step + 1 == ilen(ir_data)) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  always @(negedge clk) begin
    ov_t e;
    e = model_out(rst, m_step, m_halt, m_take, ir_data);
    n_total++;
    if (d === e) n_pass++;
    else $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, d, e);
  end

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", nm, got, exp);
  endtask

  task automatic instr(input logic [15:0] ir, input logic [15:0] b);
    ir_data = ir;
    bus     = b;
    repeat (ilen(ir)) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic cj(input logic [15:0] ir, input logic [15:0] b,
                    input logic jmp, input string nm);
    ir_data = ir;
    bus     = b;
    repeat (4) @(negedge clk);
    lit(nm, {30'd0, d.ir_out, d.pc_jump}, {30'd0, jmp, jmp});
    @(posedge clk); #1;
  endtask

  logic [15:0] tir [0:17];
  logic [15:0] tbus[0:17];

  initial begin
    tir  = '{16'h0301, 16'h0402, 16'h0503, 16'h0007, 16'h2310,
             16'h3311, 16'h4251, 16'h4252, 16'h5105, 16'h7123,
             16'h8123, 16'h9123, 16'hB40A, 16'h0B0A, 16'hE305,
             16'hF305, 16'hD305, 16'hD305};
    tbus = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005,
             16'h0001, 16'h0000, 16'h0003};
    rst = 1'b1; ir_data = 16'h112A; bus = 16'h0000;
    @(negedge clk);
    lit("reset_all_zero", 32'(d), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    lit("t0_pc_mar", {30'd0, d.pc_out, d.mar_in}, 32'd3);
    @(negedge clk);
    lit("t1_fetch", {29'd0, d.mdr_out, d.ir_in, d.pc_increment}, 32'd7);
    @(negedge clk);
    lit("setn_sel", 32'(d.reg_sel), 32'd1);
    lit("setn_strobes", {30'd0, d.ir_out, d.reg_in}, 32'd3);
    @(posedge clk); #1;
    instr(16'h112A, 16'h0000);

    instr(16'h6123, 16'h0000);
    ir_data = 16'hA123;
    repeat (3) @(negedge clk);
    lit("mod_t2_sel", 32'(d.reg_sel), 32'd2);
    @(negedge clk);
    lit("mod_t3_sel", 32'(d.reg_sel), 32'd3);
    @(negedge clk);
    lit("mod_t4_op", 32'(d.alu_op), 32'd4);
    lit("mod_t4_sel", 32'(d.reg_sel), 32'd1);
    @(posedge clk); #1;

    cj(16'hC305, 16'h0000, 1'b1, "jeqzn_taken");
    cj(16'hC305, 16'h0007, 1'b0, "jeqzn_not_taken");
    cj(16'hF305, 16'hFFFF, 1'b1, "jltzn_taken");
    cj(16'hE305, 16'h8000, 1'b0, "jgtzn_neg");

    ir_data = 16'h4250;
    repeat (3) @(negedge clk);
    lit("loadr_t2_sel", 32'(d.reg_sel), 32'd5);
    @(negedge clk);
    lit("loadr_t3_sel", 32'(d.reg_sel), 32'd2);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) instr(tir[i], tbus[i]);

    ir_data = 16'h0000;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 ir_data = 16'h112A;
    @(negedge clk);
    lit("ir_late_setn", {28'd0, d.reg_sel}, 32'd1);
    @(posedge clk); #1;

    ir_data = 16'h6123;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1; ir_data = 16'h112A;
    @(posedge clk); #1;
    @(negedge clk);
    lit("rst_mid_add", 32'(d), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    lit("after_rst_t0", {30'd0, d.pc_out, d.mar_in}, 32'd3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    ir_data = 16'h0000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lit("halt_hold", 32'(d), 32'd1);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    lit("halt_rst", 32'(d), 32'd0);
    @(posedge clk); #1 rst = 1'b0; ir_data = 16'h112A;
    @(negedge clk);
    lit("halt_restart_t0", {30'd0, d.pc_out, d.mar_in}, 32'd3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
